// File: rtl/scalar_writeback.sv
// scalar_writeback: arbitrates ALU results and in-order load returns onto one register-file write port,
// tracking outstanding load destinations in a tag FIFO plus a one-entry return skid.
module scalar_writeback #(
  parameter int BITS  = 32,
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            alu_we,
  input  logic [3:0]      alu_a3,
  input  logic [BITS-1:0] alu_wd,
  input  logic            ld_issue,
  input  logic [3:0]      ld_rd,
  output logic            ld_issue_ready,
  input  logic            ld_valid,
  input  logic [BITS-1:0] ld_data,
  output logic            ld_ready,
  output logic            we3,
  output logic [3:0]      a3,
  output logic [BITS-1:0] wd3,
  output logic [15:0]     busy,
  output logic            waw,
  output logic            illegal_wr
);
  localparam int AW = $clog2(DEPTH);
  logic [3:0]      mem [DEPTH];
  logic [AW:0]     wp, rp, cnt;
  logic [AW-1:0]   idx;
  logic            skid_v, push, pop, sel_v;
  logic [3:0]      skid_tag, sel_a;
  logic [BITS-1:0] skid_data, sel_d;
  assign cnt            = wp - rp;
  assign ld_issue_ready = cnt != (AW+1)'(DEPTH);
  assign ld_ready       = cnt != '0 && !skid_v;
  assign push           = ld_issue && ld_issue_ready;
  assign pop            = ld_valid && ld_ready;
  assign sel_v          = alu_we || skid_v;
  assign sel_a          = alu_we ? alu_a3 : skid_tag;
  assign sel_d          = alu_we ? alu_wd : skid_data;
  // Every queued tag and the skid tag mark their register busy; duplicates simply OR together.
  always_comb begin
    busy = skid_v ? 16'(1) << skid_tag : '0;
    idx  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rp[AW-1:0] + AW'(i);
      if ((AW+1)'(i) < cnt) busy = busy | (16'(1) << mem[idx]);
    end
  end
  always_ff @(posedge clk)
    if (push) mem[wp[AW-1:0]] <= ld_rd;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp         <= '0;
      rp         <= '0;
      skid_v     <= 1'b0;
      skid_tag   <= '0;
      skid_data  <= '0;
      we3        <= 1'b0;
      a3         <= '0;
      wd3        <= '0;
      waw        <= 1'b0;
      illegal_wr <= 1'b0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop) begin
        rp        <= rp + 1'b1;
        skid_v    <= 1'b1;
        skid_tag  <= mem[rp[AW-1:0]];
        skid_data <= ld_data;
      end else if (skid_v && !alu_we) skid_v <= 1'b0;
      // r15 is not writable: the slot is consumed but the write is dropped and flagged.
      we3        <= sel_v && sel_a != 4'hF;
      illegal_wr <= sel_v && sel_a == 4'hF;
      waw        <= alu_we && alu_a3 != 4'hF && busy[alu_a3];
      if (sel_v && sel_a != 4'hF) begin
        a3  <= sel_a;
        wd3 <= sel_d;
      end
    end
  end
endmodule

// File: tb/tb_scalar_writeback.sv
// tb_scalar_writeback: table vectors, directed multi-cycle sequences and a queue-based
// reference model under random stimulus.
module tb_scalar_writeback;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        alu_we = 1'b0, ld_issue = 1'b0, ld_valid = 1'b0;
  logic [3:0]  alu_a3 = '0, ld_rd = '0;
  logic [31:0] alu_wd = '0, ld_data = '0;
  logic        ld_issue_ready, ld_ready, we3, waw, illegal_wr;
  logic [3:0]  a3;
  logic [31:0] wd3;
  logic [15:0] busy;
  int errs = 0, checks = 0;

  scalar_writeback #(.BITS(32), .DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .alu_we(alu_we), .alu_a3(alu_a3), .alu_wd(alu_wd),
    .ld_issue(ld_issue), .ld_rd(ld_rd), .ld_issue_ready(ld_issue_ready),
    .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(ld_ready),
    .we3(we3), .a3(a3), .wd3(wd3), .busy(busy), .waw(waw), .illegal_wr(illegal_wr)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit we; logic [3:0] a; logic [31:0] d; bit is; logic [3:0] rd; bit v; logic [31:0] ld;
    bit e_we3; logic [3:0] e_a3; logic [31:0] e_wd3; logic [15:0] e_busy;
    bit e_lr, e_ir, e_waw, e_ill;
  } vec_t;
  vec_t tbl [12];

  int          q [$];
  bit          sk_v;
  logic [3:0]  sk_t;
  logic [31:0] sk_d;
  bit          m_we3, m_waw, m_ill;
  logic [3:0]  m_a3;
  logic [31:0] m_wd3;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input bit we, input logic [3:0] a, input logic [31:0] d,
                       input bit is, input logic [3:0] rd, input bit v, input logic [31:0] ld);
    alu_we = we; alu_a3 = a; alu_wd = d; ld_issue = is; ld_rd = rd; ld_valid = v; ld_data = ld;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    drive(0, 0, 0, 0, 0, 0, 0);
    repeat (n) tick();
  endtask

  function automatic logic [15:0] m_busy();
    logic [15:0] b = '0;
    foreach (q[i]) b[q[i]] = 1'b1;
    if (sk_v) b[sk_t] = 1'b1;
    return b;
  endfunction

  // Reference: one cycle of the writeback rules applied to the current inputs.
  task automatic model_cycle();
    logic [15:0] b = m_busy();
    bit lr = q.size() > 0 && !sk_v;
    bit ir = q.size() < 4;
    m_waw = 0;
    if (alu_we) begin
      m_we3 = alu_a3 != 15; m_ill = alu_a3 == 15;
      m_waw = alu_a3 != 15 && b[alu_a3];
      if (alu_a3 != 15) begin m_a3 = alu_a3; m_wd3 = alu_wd; end
    end else if (sk_v) begin
      m_we3 = sk_t != 15; m_ill = sk_t == 15;
      if (sk_t != 15) begin m_a3 = sk_t; m_wd3 = sk_d; end
      sk_v = 0;
    end else begin
      m_we3 = 0; m_ill = 0;
    end
    if (ld_valid && lr) begin
      sk_t = 4'(q.pop_front()); sk_d = ld_data; sk_v = 1;
    end
    if (ld_issue && ir) q.push_back(int'(ld_rd));
  endtask

  task automatic reset_all();
    #2 rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
    q.delete(); sk_v = 0;
    #3 rst_n = 1'b1;
  endtask

  initial begin
    tbl[0]  = '{1, 3, 32'hDEADBEEF, 0, 0, 0, 0,     1, 3, 32'hDEADBEEF, 16'h0000, 0, 1, 0, 0};
    tbl[1]  = '{0, 0, 0, 0, 0, 0, 0,                 0, 0, 0,            16'h0000, 0, 1, 0, 0};
    tbl[2]  = '{0, 0, 0, 1, 5, 0, 0,                 0, 0, 0,            16'h0020, 1, 1, 0, 0};
    tbl[3]  = '{1, 2, 32'h111, 0, 0, 1, 32'h12,     1, 2, 32'h111,      16'h0020, 0, 1, 0, 0};
    tbl[4]  = '{1, 5, 32'h222, 0, 0, 0, 0,          1, 5, 32'h222,      16'h0020, 0, 1, 1, 0};
    tbl[5]  = '{1, 6, 32'h333, 0, 0, 0, 0,          1, 6, 32'h333,      16'h0020, 0, 1, 0, 0};
    tbl[6]  = '{0, 0, 0, 0, 0, 0, 0,                 1, 5, 32'h12,       16'h0000, 0, 1, 0, 0};
    tbl[7]  = '{1, 15, 32'h99, 0, 0, 0, 0,          0, 0, 0,            16'h0000, 0, 1, 0, 1};
    tbl[8]  = '{0, 0, 0, 1, 15, 0, 0,                0, 0, 0,            16'h8000, 1, 1, 0, 0};
    tbl[9]  = '{0, 0, 0, 0, 0, 1, 32'h77,           0, 0, 0,            16'h8000, 0, 1, 0, 0};
    tbl[10] = '{0, 0, 0, 0, 0, 0, 0,                 0, 0, 0,            16'h0000, 0, 1, 0, 1};
    tbl[11] = '{0, 0, 0, 0, 0, 0, 0,                 0, 0, 0,            16'h0000, 0, 1, 0, 0};

    #12;
    chk("rst_we3", 32'(we3), 0); chk("rst_a3", 32'(a3), 0); chk("rst_wd3", wd3, 0);
    chk("rst_busy", 32'(busy), 0); chk("rst_ld_ready", 32'(ld_ready), 0);
    chk("rst_issue_ready", 32'(ld_issue_ready), 1);
    chk("rst_waw", 32'(waw), 0); chk("rst_ill", 32'(illegal_wr), 0);
    rst_n = 1'b1;
    #3;

    foreach (tbl[i]) begin
      drive(tbl[i].we, tbl[i].a, tbl[i].d, tbl[i].is, tbl[i].rd, tbl[i].v, tbl[i].ld);
      tick();
      chk($sformatf("tbl%0d_we3", i), 32'(we3), 32'(tbl[i].e_we3));
      if (tbl[i].e_we3) begin
        chk($sformatf("tbl%0d_a3", i), 32'(a3), 32'(tbl[i].e_a3));
        chk($sformatf("tbl%0d_wd3", i), wd3, tbl[i].e_wd3);
      end
      chk($sformatf("tbl%0d_busy", i), 32'(busy), 32'(tbl[i].e_busy));
      chk($sformatf("tbl%0d_ld_ready", i), 32'(ld_ready), 32'(tbl[i].e_lr));
      chk($sformatf("tbl%0d_issue_ready", i), 32'(ld_issue_ready), 32'(tbl[i].e_ir));
      chk($sformatf("tbl%0d_waw", i), 32'(waw), 32'(tbl[i].e_waw));
      chk($sformatf("tbl%0d_ill", i), 32'(illegal_wr), 32'(tbl[i].e_ill));
    end

    // Fill the FIFO with a duplicate tag, then drain it in order.
    begin
      logic [3:0]  rds [4]  = '{4'd1, 4'd2, 4'd1, 4'd4};
      logic [31:0] dat [4]  = '{32'hA, 32'hB, 32'hC, 32'hD};
      logic [15:0] bafter [4] = '{16'h0016, 16'h0012, 16'h0010, 16'h0000};
      foreach (rds[i]) begin drive(0, 0, 0, 1, rds[i], 0, 0); tick(); end
      chk("full_issue_ready", 32'(ld_issue_ready), 0);
      chk("full_busy", 32'(busy), 32'h0016);
      drive(0, 0, 0, 1, 9, 0, 0); tick();
      chk("fifth_issue_busy", 32'(busy), 32'h0016);
      chk("fifth_issue_ready", 32'(ld_issue_ready), 0);
      foreach (dat[i]) begin
        drive(0, 0, 0, 0, 0, 1, dat[i]); tick();
        chk($sformatf("ret%0d_ld_ready", i), 32'(ld_ready), 0);
        chk($sformatf("ret%0d_issue_ready", i), 32'(ld_issue_ready), 1);
        idle(1);
        chk($sformatf("ret%0d_we3", i), 32'(we3), 1);
        chk($sformatf("ret%0d_a3", i), 32'(a3), 32'(rds[i]));
        chk($sformatf("ret%0d_wd3", i), wd3, dat[i]);
        chk($sformatf("ret%0d_busy", i), 32'(busy), 32'(bafter[i]));
      end
    end

    // Asynchronous reset with loads outstanding and a write on the port.
    drive(0, 0, 0, 1, 3, 0, 0); tick();
    drive(1, 9, 32'h55, 1, 6, 0, 0); tick();
    chk("pre_rst_we3", 32'(we3), 1);
    chk("pre_rst_busy", 32'(busy), 32'h0048);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_busy", 32'(busy), 0);
    chk("async_rst_we3", 32'(we3), 0);
    chk("async_rst_ld_ready", 32'(ld_ready), 0);
    chk("async_rst_issue_ready", 32'(ld_issue_ready), 1);
    drive(0, 0, 0, 0, 0, 1, 32'hBAD);
    #3 rst_n = 1'b1;
    tick();
    chk("post_rst_ld_ready", 32'(ld_ready), 0);
    chk("post_rst_busy", 32'(busy), 0);
    tick();
    chk("post_rst_we3", 32'(we3), 0);

    reset_all();
    m_we3 = 0; m_waw = 0; m_ill = 0; m_a3 = 0; m_wd3 = 0;
    for (int c = 0; c < 2000; c++) begin
      drive($urandom_range(0, 99) < 35, 4'($urandom_range(0, 15)), $urandom,
            $urandom_range(0, 99) < 45, ($urandom_range(0, 3) == 0) ? 4'd15 : 4'($urandom_range(0, 7)),
            $urandom_range(0, 99) < 55, $urandom);
      model_cycle();
      tick();
      chk("rnd_we3", 32'(we3), 32'(m_we3));
      if (m_we3) begin
        chk("rnd_a3", 32'(a3), 32'(m_a3));
        chk("rnd_wd3", wd3, m_wd3);
      end
      chk("rnd_waw", 32'(waw), 32'(m_waw));
      chk("rnd_ill", 32'(illegal_wr), 32'(m_ill));
      chk("rnd_busy", 32'(busy), 32'(m_busy()));
      chk("rnd_ld_ready", 32'(ld_ready), 32'(q.size() > 0 && !sk_v));
      chk("rnd_issue_ready", 32'(ld_issue_ready), 32'(q.size() < 4));
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/scalar_writeback.md
SCALAR_WRITEBACK -- requirements
Module: scalar_writeback

Interface
REQ-001 SHALL have parameter BITS, default 32, scalar data width.
REQ-002 SHALL have parameter DEPTH, default 4, outstanding-load tag FIFO depth (power of 2, 2..16).
REQ-003 CLK  input  1  sole clock, all state on rising edge.
REQ-004 nRST  input  1  reset, asynchronous, active-low.
REQ-005 ALU_WE  input  1  single-cycle ALU result valid this cycle.
REQ-006 ALU_A3  input  4  ALU destination register.
REQ-007 ALU_WD  input  BITS  ALU result data.
REQ-008 LD_ISSUE  input  1  load issued to memory; destination given on LD_RD.
REQ-009 LD_RD  input  4  load destination register.
REQ-010 LD_ISSUE_READY  output  1  tag FIFO can accept an issue.
REQ-011 LD_VALID  input  1  memory returns load data (in issue order).
REQ-012 LD_DATA  input  BITS  returned load data.
REQ-013 LD_READY  output  1  return accepted when LD_VALID and LD_READY both high.
REQ-014 WE3  output  1  register-file write enable (registered).
REQ-015 A3  output  4  register-file write address (registered).
REQ-016 WD3  output  BITS  register-file write data (registered).
REQ-017 BUSY  output  16  bit r high = a load to register r is outstanding.
REQ-018 WAW  output  1  one-cycle pulse: accepted ALU write targets a busy register.
REQ-019 ILLEGAL_WR  output  1  one-cycle pulse: write to r15 dropped.

Function
REQ-020 Issue: LD_ISSUE with LD_ISSUE_READY pushes LD_RD into the tag FIFO; LD_ISSUE_READY = FIFO not full (same-cycle pop not considered).
REQ-021 LD_ISSUE while not ready SHALL be ignored (no push, no state change).
REQ-022 Return: one-entry skid holds {tag, data}; LD_READY = FIFO not empty AND skid empty.
REQ-023 Accepted return SHALL pop the FIFO head tag and load skid with {head tag, LD_DATA} at the same edge.
REQ-024 Arbitration per cycle: ALU_WE has priority; skid drains only in a cycle with ALU_WE low.
REQ-025 Selected write SHALL appear on WE3/A3/WD3 one edge later (latency 1); WE3 low when nothing selected.
REQ-026 Skid SHALL empty at the edge its write is registered; a new return may be accepted the following cycle.
REQ-027 BUSY SHALL be the combinational OR of decoded tags of all valid FIFO entries and the valid skid entry; duplicate tags keep the bit set until the last clears.
REQ-028 Destination 15 (ALU or load): write dropped, WE3 low that slot, ILLEGAL_WR pulsed next cycle; load entry still retires normally.
REQ-029 ALU_WE with BUSY[ALU_A3] high: write still performed, WAW pulsed one cycle later.
REQ-030 Issue and return accept in the same cycle SHALL both take effect; FIFO count unchanged.
REQ-031 FIFO pointers SHALL wrap modulo DEPTH; full/empty distinguished by an extra pointer bit or count.
REQ-032 LD_VALID with FIFO empty SHALL not be accepted (LD_READY low); data ignored.

Reset
REQ-033 nRST low SHALL immediately clear FIFO, skid, WE3=0, A3=0, WD3=0, WAW=0, ILLEGAL_WR=0; BUSY=0, LD_READY=0, LD_ISSUE_READY=1.
REQ-034 Reset mid-operation SHALL discard all outstanding loads; returns arriving after reset are not accepted until a new issue.

Verification
REQ-035 ALU_WE=1, ALU_A3=3, ALU_WD=0xDEADBEEF one cycle -> next cycle WE3=1, A3=3, WD3=0xDEADBEEF; following cycle WE3=0.
REQ-036 Issue r5, then LD_VALID LD_DATA=0x12 with ALU_WE held high 3 cycles -> BUSY[5]=1 throughout, LD_READY=0 after acceptance, WE3/A3=5/WD3=0x12 one cycle after ALU_WE drops, BUSY[5]=0 same edge.
REQ-037 Issue r1,r2,r1,r4 (DEPTH=4) -> LD_ISSUE_READY=0, fifth issue ignored; returns 0xA,0xB,0xC,0xD written to 1,2,1,4 in order; BUSY[1] clears only after third write.
REQ-038 ALU write to r15 and load to r15 -> WE3 never high for A3=15, ILLEGAL_WR pulses twice, BUSY[15] clears.
REQ-039 Issue r7, ALU write r7 -> WAW=1 one cycle; later load write overwrites r7.
REQ-040 Two loads outstanding, nRST low mid-cycle -> BUSY=0 and WE3=0 immediately; post-reset LD_VALID not accepted.
